alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Issue/retire stage wrapped around the 32-bit combinational ALU datapath (adder/subtractor, XOR, NAND and NOR units).
- Accepts one operation at a time from upstream over a valid/ready handshake and registers the operands.
- Decodes the 3-bit command into ALU control lines and holds them stable for a fixed settle window sized to cover gate propagation delay.
- Captures the result, forms the SLT result and zero flag, and presents it downstream over a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 4: clock edges from operand launch to result capture. Legal range is 1..255.
- WIDTH, 32: operand and result width. Only 32 is supported.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage can accept an operation.
- in_cmd  input  3  0=ADD, 1=SUB, 2=XOR, 3=SLT, 4=AND, 5=NAND, 6=NOR, 7=OR.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- alu_a  output  32  registered operand A to the ALU.
- alu_b  output  32  registered operand B to the ALU.
- alu_muxindex  output  2  unit select: 0=adder, 1=xor, 2=nand unit, 3=nor unit.
- alu_inverse  output  1  invert control (B inversion in adder; output inversion in nand/nor units).
- alu_carryin  output  1  adder carry-in.
- alu_res  input  32  ALU result for the selected unit.
- alu_carryout  input  1  adder carry-out.
- alu_overflow  input  1  adder signed overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_res  output  32  final result.
- out_zero  output  1  out_res == 0.
- out_carryout  output  1  carry flag.
- out_overflow  output  1  overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0; every output 0 except in_ready, which is 1. A reset arriving in SETTLE or HOLD discards the in-flight operation with no output.
- Command decode (muxindex/inverse/carryin):
  - ADD 0/0/0
  - SUB 0/1/1
  - SLT 0/1/1
  - XOR 1/0/0
  - AND 2/1/0
  - NAND 2/0/0
  - OR 3/1/0
  - NOR 3/0/0
- FSM states IDLE, SETTLE, HOLD. in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Accept: in_valid && in_ready at edge T.
  - in_a, in_b, in_cmd and the decoded controls are registered onto the alu_* outputs and the command register.
  - Counter loads SETTLE_CYCLES-1; state goes to SETTLE.
- SETTLE: counter decrements each edge. On the edge where counter==0, capture into the out_* registers and go to HOLD with out_valid=1. out_valid therefore rises after edge T+SETTLE_CYCLES.
- Capture rules:
  - ADD/SUB: out_res = alu_res; out_carryout = alu_carryout; out_overflow = alu_overflow.
  - SLT: out_res = {31'b0, alu_res[31] ^ alu_overflow}; flags = adder flags.
  - Logic ops: out_res = alu_res; out_carryout = 0; out_overflow = 0.
  - out_zero = (out_res == 0), computed on the final out_res.
- HOLD: all out_* outputs are held stable while out_ready is low. On out_valid && out_ready, out_valid clears and state goes to IDLE.
- Same-edge accept: if in_valid is also high on that edge, the new operation is accepted on the same edge and state goes directly to SETTLE.
- alu_* outputs change only on an accept edge. They stay stable through SETTLE and HOLD and persist into IDLE.
- in_valid while busy (SETTLE, or HOLD without out_ready) is ignored. Upstream holds its data until in_ready.
- Issue interval is SETTLE_CYCLES+1 cycles under no backpressure.

Test Plan:
- SUB, a=0x00000802, b=1, SETTLE_CYCLES=4, out_ready=1 -> alu_muxindex=0, alu_inverse=1, alu_carryin=1 from T+1. out_valid after T+4 with out_res=0x00000801, carryout=1, overflow=0, zero=0.
- ADD, a=0xFFFFFFFF, b=1 -> out_res=0, zero=1, carryout=1, overflow=0.
- SLT pair:
  - a=0xFFFFFFFF, b=1 -> out_res=1.
  - a=0x80000000, b=1 (overflow case) -> out_res=1, overflow=1.
  - a=5, b=3 -> out_res=0, zero=1.
- AND, a=0xF0F0F0F0, b=0xFF00FF00 -> muxindex=2, inverse=1, out_res=0xF000F000, carryout=0, overflow=0.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_res stable, in_ready=0, a second in_valid ignored. Raising out_ready with in_valid high -> same-edge accept and new result SETTLE_CYCLES later.
- Reset pulse mid-SETTLE (rst_n low between edges) -> outputs 0 and in_ready=1 immediately with no clock. After release, the next op completes normally.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundle of the upstream issue handshake, the ALU control/result bus and the
// downstream retire handshake around the ALU sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_cmd;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_muxindex;
    logic             alu_inverse;
    logic             alu_carryin;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carryout;
    logic             alu_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_zero;
    logic             out_carryout;
    logic             out_overflow;

    // Sequencer side
    modport slave (
        input  in_valid, in_cmd, in_a, in_b,
        output in_ready,
        output alu_a, alu_b, alu_muxindex, alu_inverse, alu_carryin,
        input  alu_res, alu_carryout, alu_overflow,
        output out_valid, out_res, out_zero, out_carryout, out_overflow,
        input  out_ready
    );

    // Environment side: upstream producer, ALU datapath and downstream consumer
    modport master (
        output in_valid, in_cmd, in_a, in_b,
        input  in_ready,
        input  alu_a, alu_b, alu_muxindex, alu_inverse, alu_carryin,
        output alu_res, alu_carryout, alu_overflow,
        input  out_valid, out_res, out_zero, out_carryout, out_overflow,
        output out_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/retire stage around the combinational 32-bit ALU datapath.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no operation in flight, ready for upstream
// SETTLE | operands/controls launched, counting down the settle window
// HOLD   | result captured, presented downstream until accepted
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int WIDTH         = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [2:0]       r_cmd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_mux;
    logic             r_inv;
    logic             r_cin;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_zero;
    logic             r_out_cout;
    logic             r_out_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_capture;
    logic             w_retire;
    logic [1:0]       w_mux;
    logic             w_inv;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH-1:0] w_cap_res;

    assign w_in_ready = (r_state == IDLE) || ((r_state == HOLD) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_capture  = (r_state == SETTLE) && (r_cnt == 8'd0);
    assign w_retire   = (r_state == HOLD) && bus.out_ready;

    // Decode the incoming command into ALU unit select and control lines
    always_comb begin
        w_mux = 2'd0;
        w_inv = 1'b0;
        w_cin = 1'b0;
        case (bus.in_cmd)
            CMD_ADD:  begin w_mux = 2'd0; end
            CMD_SUB:  begin w_mux = 2'd0; w_inv = 1'b1; w_cin = 1'b1; end
            CMD_SLT:  begin w_mux = 2'd0; w_inv = 1'b1; w_cin = 1'b1; end
            CMD_XOR:  begin w_mux = 2'd1; end
            CMD_AND:  begin w_mux = 2'd2; w_inv = 1'b1; end
            CMD_NAND: begin w_mux = 2'd2; end
            CMD_OR:   begin w_mux = 2'd3; w_inv = 1'b1; end
            CMD_NOR:  begin w_mux = 2'd3; end
            default:  begin w_mux = 2'd0; end
        endcase
    end

    // Form the value to capture: SLT reduces the subtraction to a sign bit
    // corrected for overflow; only adder-based commands keep adder flags
    always_comb begin
        w_arith   = (r_cmd == CMD_ADD) || (r_cmd == CMD_SUB) || (r_cmd == CMD_SLT);
        w_cap_res = bus.alu_res;
        if (r_cmd == CMD_SLT) begin
            w_cap_res = {{(WIDTH-1){1'b0}}, bus.alu_res[WIDTH-1] ^ bus.alu_overflow};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SETTLE;
            SETTLE:  if (w_capture) w_state_nxt = HOLD;
            HOLD:    if (w_retire) w_state_nxt = bus.in_valid ? SETTLE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Settle down-counter, loaded on accept and terminating at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == SETTLE) && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Operand and control launch registers, updated only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd   <= 3'd0;
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_mux   <= 2'd0;
            r_inv   <= 1'b0;
            r_cin   <= 1'b0;
        end else if (w_accept) begin
            r_cmd   <= bus.in_cmd;
            r_alu_a <= bus.in_a;
            r_alu_b <= bus.in_b;
            r_mux   <= w_mux;
            r_inv   <= w_inv;
            r_cin   <= w_cin;
        end
    end

    // Result capture at the end of the settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_res  <= '0;
            r_out_zero <= 1'b0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else if (w_capture) begin
            r_out_res  <= w_cap_res;
            r_out_zero <= (w_cap_res == '0);
            r_out_cout <= w_arith && bus.alu_carryout;
            r_out_ovf  <= w_arith && bus.alu_overflow;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;
    assign bus.alu_muxindex = r_mux;
    assign bus.alu_inverse  = r_inv;
    assign bus.alu_carryin  = r_cin;
    assign bus.out_valid    = (r_state == HOLD);
    assign bus.out_res      = r_out_res;
    assign bus.out_zero     = r_out_zero;
    assign bus.out_carryout = r_out_cout;
    assign bus.out_overflow = r_out_ovf;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the ALU datapath.
module tb_alu_sequencer;
    localparam int S = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_sequencer_if #(.WIDTH(32)) bif ();

    alu_sequencer #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: adder/subtractor, XOR, NAND-with-inverse, NOR-with-inverse
    logic [31:0] m_bop;
    logic [32:0] m_sum;
    always_comb begin
        m_bop = bif.alu_inverse ? ~bif.alu_b : bif.alu_b;
        m_sum = {1'b0, bif.alu_a} + {1'b0, m_bop} + {32'd0, bif.alu_carryin};
        bif.alu_carryout = m_sum[32];
        bif.alu_overflow = (bif.alu_a[31] == m_bop[31]) && (m_sum[31] != bif.alu_a[31]);
        case (bif.alu_muxindex)
            2'd0:    bif.alu_res = m_sum[31:0];
            2'd1:    bif.alu_res = bif.alu_a ^ bif.alu_b;
            2'd2:    bif.alu_res = bif.alu_inverse ? (bif.alu_a & bif.alu_b) : ~(bif.alu_a & bif.alu_b);
            default: bif.alu_res = bif.alu_inverse ? (bif.alu_a | bif.alu_b) : ~(bif.alu_a | bif.alu_b);
        endcase
    end

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mux;
        logic        inv;
        logic        cin;
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_cmd   = cmd;
        bif.in_a     = a;
        bif.in_b     = b;
        n = 0;
        while (!bif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int lat;
        lat = 0;
        while (!bif.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'(S));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //          cmd   a             b             mux  inv  cin  res           z     c     o
        vecs[0]  = '{3'd1, 32'h00000802, 32'h00000001, 2'd0, 1'b1, 1'b1, 32'h00000801, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 2'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 2'd0, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'd3, 32'h80000000, 32'h00000001, 2'd0, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'd3, 32'h00000005, 32'h00000003, 2'd0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 2'd2, 1'b1, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 2'd1, 1'b0, 1'b0, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 2'd2, 1'b0, 1'b0, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd7, 32'h00FF0000, 32'h0000FF00, 2'd3, 1'b1, 1'b0, 32'h00FFFF00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd6, 32'h0000FFFF, 32'hFFFF0000, 2'd3, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd2, 32'h12345678, 32'h12345678, 2'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 2'd0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_cmd    = 3'd0;
        bif.in_a      = 32'd0;
        bif.in_b      = 32'd0;
        bif.out_ready = 1'b1;
        #2;
        check("rst.in_ready", 32'(bif.in_ready), 32'd1);
        check("rst.out_valid", 32'(bif.out_valid), 32'd0);
        check("rst.alu_a", bif.alu_a, 32'd0);
        check("rst.out_res", bif.out_res, 32'd0);
        check("rst.ctrl", {29'd0, bif.alu_muxindex, bif.alu_inverse}, 32'd0);
        n_vec++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b);
            check({nm, ".alu_a"}, bif.alu_a, vecs[i].a);
            check({nm, ".alu_b"}, bif.alu_b, vecs[i].b);
            check({nm, ".ctrl"}, {28'd0, bif.alu_muxindex, bif.alu_inverse, bif.alu_carryin},
                  {28'd0, vecs[i].mux, vecs[i].inv, vecs[i].cin});
            check({nm, ".in_ready_busy"}, 32'(bif.in_ready), 32'd0);
            wait_valid(nm);
            check({nm, ".res"}, bif.out_res, vecs[i].res);
            check({nm, ".flags"}, {29'd0, bif.out_zero, bif.out_carryout, bif.out_overflow},
                  {29'd0, vecs[i].zero, vecs[i].cout, vecs[i].ovf});
            @(posedge clk);
            #1;
            check({nm, ".retired"}, 32'(bif.out_valid), 32'd0);
            n_vec++;
        end

        // Backpressure, ignored issue while busy, then same-edge accept
        bif.out_ready = 1'b0;
        issue(3'd0, 32'd3, 32'd4);
        wait_valid("bp");
        check("bp.res", bif.out_res, 32'd7);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_cmd   = 3'd2;
        bif.in_a     = 32'h000000AA;
        bif.in_b     = 32'h00000055;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp.hold_res", bif.out_res, 32'd7);
            check("bp.hold_valid", 32'(bif.out_valid), 32'd1);
            check("bp.in_ready", 32'(bif.in_ready), 32'd0);
            check("bp.alu_a", bif.alu_a, 32'd3);
        end
        @(negedge clk);
        bif.out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(bif.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        check("bp.same_edge_alu_a", bif.alu_a, 32'h000000AA);
        check("bp.same_edge_mux", 32'(bif.alu_muxindex), 32'd1);
        check("bp.same_edge_valid", 32'(bif.out_valid), 32'd0);
        wait_valid("bp2");
        check("bp2.res", bif.out_res, 32'h000000FF);
        @(posedge clk);
        #1;
        n_vec++;

        // Asynchronous reset between edges while in SETTLE
        issue(3'd1, 32'h00000100, 32'h00000001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.in_ready", 32'(bif.in_ready), 32'd1);
        check("arst.out_valid", 32'(bif.out_valid), 32'd0);
        check("arst.out_res", bif.out_res, 32'd0);
        check("arst.alu_a", bif.alu_a, 32'd0);
        check("arst.ctrl", {29'd0, bif.alu_muxindex, bif.alu_inverse}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 2) begin
            @(posedge clk);
            #1;
            check("arst.no_output", 32'(bif.out_valid), 32'd0);
        end
        issue(3'd0, 32'd2, 32'd2);
        wait_valid("post_rst");
        check("post_rst.res", bif.out_res, 32'd4);
        check("post_rst.flags", {29'd0, bif.out_zero, bif.out_carryout, bif.out_overflow}, 32'd0);
        @(posedge clk);
        #1;
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
